// File: rtl/window_gen_3x3_if.sv
// Pixel-in / window-out bundle between the greyscale stage, the 3x3 window
// generator and the convolution block. Clock and reset stay outside.
interface window_gen_3x3_if;
   logic [7:0]  i_pixel;
   logic        i_pixel_valid;
   logic        i_sof;
   logic [71:0] o_pixel_data;
   logic        o_pixel_data_valid;
   logic        o_eof;

   modport master (
      output i_pixel, i_pixel_valid, i_sof,
      input  o_pixel_data, o_pixel_data_valid, o_eof
   );

   modport slave (
      input  i_pixel, i_pixel_valid, i_sof,
      output o_pixel_data, o_pixel_data_valid, o_eof
   );
endinterface

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift
// window; emits one packed window per interior pixel, one cycle after it.
module window_gen_3x3 #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input logic             i_clk,
   input logic             i_rst_n,
   window_gen_3x3_if.slave bus
);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   col_q, col_d, cur_col;
   logic [RW-1:0]   row_q, row_d, cur_row;
   logic            accept, last_pix, gate;

   logic [7:0]      lb_top [IMG_WIDTH];
   logic [7:0]      lb_mid [IMG_WIDTH];
   logic [7:0]      win_q  [3][3];
   logic [7:0]      win_d  [3][3];

   logic [71:0]     data_d, data_q;
   logic            valid_q, eof_q;

   // A valid i_sof forces the incoming pixel to (0,0) regardless of counters.
   assign cur_col  = bus.i_sof ? '0 : col_q;
   assign cur_row  = bus.i_sof ? '0 : row_q;
   assign last_pix = (cur_row == RW'(IMG_HEIGHT - 1)) && (cur_col == CW'(IMG_WIDTH - 1));
   assign gate     = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));

   // NOTE: every always_comb output gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      if (bus.i_pixel_valid) begin
         if (bus.i_sof) begin
            accept  = 1'b1;
            state_d = RUN;
         end else if (state_q == RUN) begin
            accept = 1'b1;
         end
      end
      if (accept && last_pix) state_d = DONE;
   end

   always_comb begin
      col_d = cur_col;
      row_d = cur_row;
      if (cur_col == CW'(IMG_WIDTH - 1)) begin
         col_d = '0;
         row_d = (cur_row == RW'(IMG_HEIGHT - 1)) ? '0 : cur_row + RW'(1);
      end else begin
         col_d = cur_col + CW'(1);
      end
   end

   // Shift left by one column; the new right column comes from the line
   // buffers (older lines) and the incoming pixel (newest line).
   always_comb begin
      data_d = '0;
      for (int r = 0; r < 3; r++) begin
         win_d[r][0] = win_q[r][1];
         win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb_top[cur_col];
      win_d[1][2] = lb_mid[cur_col];
      win_d[2][2] = bus.i_pixel;
      for (int i = 0; i < 9; i++) data_d[i*8 +: 8] = win_d[i/3][i%3];
   end

   // NOTE: line buffers and the window array carry no reset; stale contents
   // are never visible because output is gated by the row/col position.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         lb_top[cur_col] <= lb_mid[cur_col];
         lb_mid[cur_col] <= bus.i_pixel;
         win_q           <= win_d;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         eof_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            col_q <= col_d;
            row_q <= row_d;
         end
         valid_q <= gate;
         eof_q   <= gate && last_pix;
         if (gate) data_q <= data_d;
      end
   end

   assign bus.o_pixel_data       = data_q;
   assign bus.o_pixel_data_valid = valid_q;
   assign bus.o_eof              = eof_q;
endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed and random-frame bench for window_gen_3x3 on a 4x4 image with a
// queue scoreboard of expected windows.
module tb_window_gen_3x3;
   localparam int W = 4;
   localparam int H = 4;

   logic i_clk = 1'b0;
   logic i_rst_n;
   window_gen_3x3_if bus ();

   window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus)
   );

   always #5 i_clk = ~i_clk;

   int           tests = 0;
   int           fails = 0;
   logic [72:0]  sb [$];
   logic [7:0]   img [H][W];
   logic [71:0]  hold_exp = '0;
   logic [71:0]  first_obs, last_obs;
   int           win_cnt, eof_cnt;

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [71:0] win_of(input int r, input int c);
      logic [71:0] w;
      for (int i = 0; i < 9; i++) w[i*8 +: 8] = img[r - 2 + i/3][c - 2 + i%3];
      return w;
   endfunction

   // One clock: drive inputs, push any expected window, sample at negedge.
   task automatic step(input logic rst, input logic v, input logic sof, input logic [7:0] pix,
                       input logic exp_v, input logic [71:0] exp_d, input logic exp_e);
      logic [72:0] e;
      i_rst_n           = rst;
      bus.i_pixel_valid = v;
      bus.i_sof         = sof;
      bus.i_pixel       = pix;
      if (!rst) begin
         sb.delete();
         hold_exp = '0;
      end else if (exp_v) begin
         sb.push_back({exp_e, exp_d});
      end
      @(posedge i_clk);
      @(negedge i_clk);
      check("valid", 72'(bus.o_pixel_data_valid), 72'(exp_v && rst));
      if (bus.o_pixel_data_valid && sb.size() > 0) begin
         e = sb.pop_front();
         check("window", bus.o_pixel_data, e[71:0]);
         check("eof", 72'(bus.o_eof), 72'(e[72]));
         hold_exp = e[71:0];
      end else if (!bus.o_pixel_data_valid) begin
         check("hold", bus.o_pixel_data, hold_exp);
         check("eof_idle", 72'(bus.o_eof), 72'(0));
      end
      if (bus.o_pixel_data_valid) begin
         if (win_cnt == 0) first_obs = bus.o_pixel_data;
         last_obs = bus.o_pixel_data;
         win_cnt++;
      end
      if (bus.o_eof) eof_cnt++;
   endtask

   // gap_mode: 0 none, 1 gap before every pixel, 2 random gaps.
   task automatic send_frame(input int gap_mode, input bit rnd);
      logic [7:0] p;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0))
               step(1'b1, 1'b0, 1'($urandom), 8'($urandom), 1'b0, '0, 1'b0);
            p = rnd ? 8'($urandom) : 8'(r * 16 + c);
            img[r][c] = p;
            step(1'b1, 1'b1, (r == 0 && c == 0), p, (r >= 2 && c >= 2),
                 (r >= 2 && c >= 2) ? win_of(r, c) : '0, (r == H - 1 && c == W - 1));
         end
      end
   endtask

   task automatic stray(input int n);
      for (int k = 0; k < n; k++) step(1'b1, 1'b1, 1'b0, 8'($urandom), 1'b0, '0, 1'b0);
   endtask

   initial begin
      bus.i_pixel       = '0;
      bus.i_pixel_valid = 1'b0;
      bus.i_sof         = 1'b0;
      i_rst_n           = 1'b0;
      @(negedge i_clk);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, '0, 1'b0);

      // Back-to-back frame straight after reset.
      win_cnt = 0; eof_cnt = 0;
      send_frame(0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, '0, 1'b0);
      check("first_win", first_obs, 72'h22_21_20_12_11_10_02_01_00);
      check("last_win", last_obs, 72'h33_32_31_23_22_21_13_12_11);
      check("win_count", 72'(win_cnt), 72'(4));
      check("eof_count", 72'(eof_cnt), 72'(1));

      // Alternate-cycle gaps, preceded by pixels in DONE.
      stray(5);
      win_cnt = 0; eof_cnt = 0;
      send_frame(1, 1'b0);
      check("gap_last_win", last_obs, 72'h33_32_31_23_22_21_13_12_11);
      check("gap_win_count", 72'(win_cnt), 72'(4));

      // Restart at (2,1): partial frame abandoned by a new i_sof.
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < W; c++)
            if (r < 2 || c == 0)
               step(1'b1, 1'b1, (r == 0 && c == 0), 8'(r * 16 + c), 1'b0, '0, 1'b0);
      win_cnt = 0;
      send_frame(0, 1'b0);
      check("restart_win_count", 72'(win_cnt), 72'(4));

      // Reset mid-frame with a valid pixel present, then ignored pixels.
      for (int c = 0; c < W; c++)
         step(1'b1, 1'b1, (c == 0), 8'(c), 1'b0, '0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 8'h55, 1'b0, '0, 1'b0);
      check("rst_data", bus.o_pixel_data, 72'h0);
      stray(W * H);
      win_cnt = 0; eof_cnt = 0;
      send_frame(0, 1'b0);
      check("post_rst_first", first_obs, 72'h22_21_20_12_11_10_02_01_00);
      check("post_rst_count", 72'(win_cnt), 72'(4));

      // Random pixels and random gaps over several frames.
      win_cnt = 0; eof_cnt = 0;
      for (int f = 0; f < 6; f++) begin
         send_frame(2, 1'b1);
         stray($urandom_range(0, 3));
      end
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, '0, 1'b0);
      check("rnd_win_count", 72'(win_cnt), 72'(6 * (W - 2) * (H - 2)));
      check("rnd_eof_count", 72'(eof_cnt), 72'(6));
      check("sb_drained", 72'(sb.size()), 72'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/window_gen_3x3.md
# window_gen_3x3

Streaming 3x3 neighbourhood generator that feeds the convolution stage. It accepts one 8-bit greyscale pixel per valid cycle in raster order and keeps two full-line buffers. For every pixel whose 3x3 neighbourhood lies completely inside the frame, it emits a packed 72-bit window plus a valid strobe. It sits between the camera capture/greyscale stage and the convolution/filter block, and drives that block's window and valid inputs directly.

## Interface
- IMG_WIDTH, 640, pixels per line; must be ≥ 3.
- IMG_HEIGHT, 480, lines per frame; must be ≥ 3.
- i_clk  in  1  single clock; all logic on its rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_pixel  in  8  input pixel, unsigned.
- i_pixel_valid  in  1  i_pixel is accepted on this cycle.
- i_sof  in  1  start of frame; meaningful only when i_pixel_valid=1; marks that pixel as (row 0, col 0).
- o_pixel_data  out  72  3x3 window; byte i = o_pixel_data[i*8 +: 8].
- o_pixel_data_valid  out  1  o_pixel_data holds a new window this cycle.
- o_eof  out  1  one-cycle pulse coincident with the last window of the frame.

## Operation
- Window packing is row-major. Byte i is at window row i/3 and column i%3.
  - Row 0 is the oldest line (top); column 0 is the oldest pixel (left).
  - Byte 4 is the centre pixel, at (r-1, c-1) relative to the newest pixel (r, c).
- Storage:
  - Two line buffers of IMG_WIDTH x 8 bits, read asynchronously: lb_top holds line r-2 and lb_mid holds line r-1.
  - A 3x3 register array holds the window.
- States: IDLE, RUN, DONE.
  - Reset goes to IDLE.
  - IDLE: pixels are ignored until a pixel arrives with i_sof=1.
  - That pixel is accepted as (0,0) and the state moves to RUN.
  - RUN: every pixel with i_pixel_valid=1 is accepted.
  - After the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted, the state moves to DONE.
  - DONE: pixels are ignored until the next pixel with i_sof=1, which restarts at (0,0) in RUN.
- A pixel with i_pixel_valid=1 and i_sof=1 restarts from any state, including mid-frame.
  - That pixel is (0,0) and the counters are forced to it.
  - Window and line-buffer contents are not cleared. Stale data can never be emitted because the row/col gating below suppresses it.
- On each accepted pixel at (r, c):
  - Every window row shifts one column left: column 0 is dropped, column 1 moves to column 0, column 2 moves to column 1.
  - The new column 2 is {lb_top[c], lb_mid[c], i_pixel} for rows 0, 1, 2 respectively.
  - The buffers update as lb_top[c] ← lb_mid[c] and lb_mid[c] ← i_pixel.
  - The column counter increments and wraps from IMG_WIDTH-1 to 0. On wrap the row counter increments.
- Window gating: o_pixel_data_valid=1 on the cycle after an accepted pixel with r ≥ 2 and c ≥ 2.
  - The window is not emitted across a line wrap; columns 0 and 1 never produce output.
  - Result: exactly (IMG_WIDTH-2)·(IMG_HEIGHT-2) windows per frame.
  - No padding and no border output.
- o_eof=1 together with the window produced by pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- Counter widths are $clog2 of the respective parameter. The row counter never exceeds IMG_HEIGHT-1.

## Timing
- Reset values:
  - o_pixel_data = 0, o_pixel_data_valid = 0, o_eof = 0.
  - State IDLE, both counters 0.
  - Line buffers are not reset.
- Latency is 1 cycle from an accepted pixel to its window on o_pixel_data / o_pixel_data_valid.
- o_pixel_data_valid and o_eof are single-cycle strobes; they are 0 on every cycle not following a qualifying accept.
- o_pixel_data holds its last value when valid is 0.
- Gaps are supported: a cycle with i_pixel_valid=0 changes no window, buffer or counter, and gives o_pixel_data_valid=0 on the next cycle.
- There is no backpressure; the consumer must take every window.
- Reset mid-frame wins over everything, including a simultaneous i_pixel_valid/i_sof. The block returns to IDLE on the next edge with outputs at 0.
- i_sof with i_pixel_valid=0 is ignored.

## Test plan
Use IMG_WIDTH=4, IMG_HEIGHT=4 and pixel value = row·16+col (hex) unless noted.
- **Full frame, back-to-back after reset, i_sof on the first pixel.**
  - Exactly 4 windows appear, one cycle after pixels (2,2), (2,3), (3,2), (3,3).
  - The first window is o_pixel_data = 0x22_21_20_12_11_10_02_01_00.
  - The last window is 0x33_32_31_23_22_21_13_12_11, with o_eof=1 on that cycle only.
- **Same frame with i_pixel_valid low on alternate cycles.**
  - Identical 4 windows and o_eof; no valid output during gaps or in the cycle after a gap.
- **Pixels before any i_sof, and pixels after frame end (DONE).**
  - No o_pixel_data_valid.
  - A following i_sof frame produces the same 4 windows as the first scenario.
- **i_sof asserted at pixel (2,1) of a frame (new frame restarts there).**
  - No window until the new frame's pixel (2,2).
  - The new frame then produces its 4 correct windows.
- **i_rst_n=0 for one cycle mid-frame, coincident with i_pixel_valid=1.**
  - All outputs 0 next cycle.
  - Subsequent pixels are ignored until i_sof; then normal output.
- **IMG_WIDTH=640, IMG_HEIGHT=480, random pixels, random gaps.**
  - 638·478 = 304964 windows matching a software 3x3 reference.
  - One o_eof per frame.
